fifo_ctrl_arb: RTL and testbench

Controller and round-robin arbiter that drains N source FIFOs into one destination FIFO, one word per cycle. It also configures the almost-full and almost-empty thresholds of every attached FIFO after reset. It sits between the per-lane input FIFOs and the shared output FIFO of the datapath, driving their `fifo_rd` / `fifo_wr` strobes and threshold inputs.

---
 rtl/fifo_ctrl_pkg.sv | 21 ++
 rtl/fifo_ctrl_arb_rr_pick.sv | 33 +++
 rtl/fifo_ctrl_arb.sv | 144 ++++++++++++++
 tb/tb_fifo_ctrl_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO drain controller / round-robin arbiter.
// The optional error flag is enabled by defining ARB_ERR_EN (see fifo_ctrl_arb).
package fifo_ctrl_pkg;

   localparam int N_IN_DEF   = 4;
   localparam int DATA_W_DEF = 6;
   localparam int ADDR_W_DEF = 3;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_e;

   // Width of a lane index; a single lane still needs one bit to hold index 0.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_ctrl_arb_rr_pick.sv
// Combinational round-robin picker: grants the first requester strictly after
// the previous grant, wrapping around, so every lane gets a turn.
module rr_pick
   import fifo_ctrl_pkg::*;
#(
   parameter int N     = N_IN_DEF,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      logic [IDX_W-1:0] j;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      j     = '0;
      // Offset N wraps back to the last winner itself, so a lone requester is re-picked.
      for (int k = 1; k <= N; k++) begin
         j = IDX_W'((int'(last) + k) % N);
         if (!valid && req[j]) begin
            valid  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/fifo_ctrl_arb.sv
// Drains N_IN source FIFOs into one destination FIFO, one word per cycle, and
// programs FIFO thresholds while in INIT. Define ARB_ERR_EN for the sticky err_full flag.
module fifo_ctrl_arb
   import fifo_ctrl_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     RESET_L,
   input  logic                     init,
   input  logic [ADDR_W-1:0]        umbral_full,
   input  logic [ADDR_W-1:0]        umbral_empty,
   input  logic [N_IN-1:0]          src_empty,
   input  logic [N_IN*DATA_W-1:0]   src_data,
   output logic [N_IN-1:0]          src_rd,
   input  logic                     dst_full,
   input  logic                     dst_al_full,
   output logic                     dst_wr,
   output logic [DATA_W-1:0]        dst_data,
   output logic [ADDR_W-1:0]        al_full_cfg,
   output logic [ADDR_W-1:0]        al_empty_cfg,
   output logic [1:0]               state,
   output logic                     idle,
   output logic                     err_full
);

   localparam int IDX_W = idx_w(N_IN);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
   logic                dst_wr_q, dst_wr_d;
   logic                idle_q, idle_d;
   logic [ADDR_W-1:0]   al_full_q, al_full_d;
   logic [ADDR_W-1:0]   al_empty_q, al_empty_d;

   logic [N_IN-1:0]     pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_valid;
   logic                rd_en;
   logic [DATA_W-1:0]   lane_data [N_IN];

   rr_pick #(
      .N     (N_IN),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (~src_empty),
      .last  (last_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
      assign lane_data[gi] = src_data[gi*DATA_W +: DATA_W];
   end

   // Reads are combinational so a dst_al_full rise suppresses the strobe in the same cycle.
   assign rd_en  = (state_q == ST_ACTIVE) && pick_valid && !dst_al_full && !dst_full;
   assign src_rd = rd_en ? pick_gnt : '0;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_idx_d = grant_idx_q;
      al_full_d   = al_full_q;
      al_empty_d  = al_empty_q;
      dst_wr_d    = rd_en;

      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init) state_d = ST_IDLE;
         ST_IDLE: begin
            if (init)                          state_d = ST_INIT;
            else if (pick_valid && !dst_al_full) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (init)             state_d = ST_INIT;
            else if (!pick_valid) state_d = ST_IDLE;
         end
         default:   state_d = ST_RESET;
      endcase

      if (state_q == ST_INIT) begin
         al_full_d  = umbral_full;
         al_empty_d = umbral_empty;
      end

      if (rd_en) begin
         last_d      = pick_idx;
         grant_idx_d = pick_idx;
      end

      idle_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q     <= ST_RESET;
         last_q      <= IDX_W'(N_IN - 1);
         grant_idx_q <= '0;
         dst_wr_q    <= 1'b0;
         idle_q      <= 1'b0;
         al_full_q   <= '0;
         al_empty_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         grant_idx_q <= grant_idx_d;
         dst_wr_q    <= dst_wr_d;
         idle_q      <= idle_d;
         al_full_q   <= al_full_d;
         al_empty_q  <= al_empty_d;
      end
   end

   // Source data_out lands one cycle after the read; gate with dst_wr so reset drives 0.
   assign dst_data     = dst_wr_q ? lane_data[grant_idx_q] : '0;
   assign dst_wr       = dst_wr_q;
   assign al_full_cfg  = al_full_q;
   assign al_empty_cfg = al_empty_q;
   assign state        = state_q;
   assign idle         = idle_q;

`ifdef ARB_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (dst_wr_q & dst_full);
   end

   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign err_full = err_q;
`else
   assign err_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Directed bench for fifo_ctrl_arb: behavioural source FIFOs, per-cycle logs and
// hand-computed expected tables for grants, writes, data, state and flags.
module tb_fifo_ctrl_arb;

   logic        clk = 1'b0;
   logic        RESET_L, init, dst_full, dst_al_full;
   logic [2:0]  umbral_full, umbral_empty;
   logic [3:0]  src_empty, src_rd;
   logic [23:0] src_data;
   logic        dst_wr, idle, err_full;
   logic [5:0]  dst_data;
   logic [2:0]  al_full_cfg, al_empty_cfg;
   logic [1:0]  state;

`ifdef ARB_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [5:0] mem [4][8];
   int         cnt [4];
   int         rp  [4];
   int         wp  [4];
   logic [5:0] dout [4];

   logic [3:0] rd_log  [16];
   logic [3:0] exp_rd  [16];
   logic       wr_log  [16];
   logic       exp_wr  [16];
   logic [5:0] dat_log [16];
   logic [5:0] exp_dat [16];
   logic       idle_log [16];
   logic       err_log  [16];
   logic [1:0] st_log   [16];
   logic [15:0] al_sched, full_sched;
   int ncyc, bad_rd, bad_oh;

   always #5 clk = ~clk;

   fifo_ctrl_arb dut (
      .clk          (clk),
      .RESET_L      (RESET_L),
      .init         (init),
      .umbral_full  (umbral_full),
      .umbral_empty (umbral_empty),
      .src_empty    (src_empty),
      .src_data     (src_data),
      .src_rd       (src_rd),
      .dst_full     (dst_full),
      .dst_al_full  (dst_al_full),
      .dst_wr       (dst_wr),
      .dst_data     (dst_data),
      .al_full_cfg  (al_full_cfg),
      .al_empty_cfg (al_empty_cfg),
      .state        (state),
      .idle         (idle),
      .err_full     (err_full)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         src_empty[i]          = (cnt[i] == 0);
         src_data[i*6 +: 6]    = dout[i];
      end
   endtask

   task automatic load(input int lane, input logic [5:0] w);
      mem[lane][wp[lane] % 8] = w;
      wp[lane]++;
      cnt[lane]++;
      refresh();
   endtask

   // One clock: apply scheduled backpressure, sample at negedge, then let the
   // sources consume whatever read strobe was present at the rising edge.
   task automatic cycle();
      logic [3:0] rd_s;
      dst_al_full = al_sched[ncyc];
      dst_full    = full_sched[ncyc];
      @(negedge clk);
      rd_log[ncyc]   = src_rd;
      wr_log[ncyc]   = dst_wr;
      dat_log[ncyc]  = dst_data;
      idle_log[ncyc] = idle;
      err_log[ncyc]  = err_full;
      st_log[ncyc]   = state;
      rd_s = src_rd;
      for (int i = 0; i < 4; i++)
         if (rd_s[i] && cnt[i] == 0) bad_rd++;
      if ($countones(rd_s) > 1) bad_oh++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (rd_s[i] && cnt[i] > 0) begin
            dout[i] = mem[i][rp[i] % 8];
            rp[i]++;
            cnt[i]--;
         end
      end
      refresh();
      ncyc++;
   endtask

   task automatic run(input int n);
      ncyc = 0;
      repeat (n) cycle();
   endtask

   task automatic check_run(input string nm, input int n);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s rd[%0d]", nm, k), 32'(rd_log[k]), 32'(exp_rd[k]));
         chk($sformatf("%s wr[%0d]", nm, k), 32'(wr_log[k]), 32'(exp_wr[k]));
         if (exp_wr[k])
            chk($sformatf("%s data[%0d]", nm, k), 32'(dat_log[k]), 32'(exp_dat[k]));
      end
   endtask

   task automatic clear_sched();
      al_sched   = '0;
      full_sched = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      RESET_L      = 1'b0;
      init         = 1'b1;
      umbral_full  = 3'd6;
      umbral_empty = 3'd2;
      dst_full     = 1'b0;
      dst_al_full  = 1'b0;
      bad_rd       = 0;
      bad_oh       = 0;
      ncyc         = 0;
      clear_sched();
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0; rp[i] = 0; wp[i] = 0; dout[i] = '0;
      end
      refresh();

      // Reset values and threshold programming
      #12;
      chk("rst state",    32'(state),        32'd0);
      chk("rst src_rd",   32'(src_rd),       32'd0);
      chk("rst dst_wr",   32'(dst_wr),       32'd0);
      chk("rst dst_data", 32'(dst_data),     32'd0);
      chk("rst al_full",  32'(al_full_cfg),  32'd0);
      chk("rst al_empty", 32'(al_empty_cfg), 32'd0);
      chk("rst idle",     32'(idle),         32'd0);
      chk("rst err",      32'(err_full),     32'd0);
      RESET_L = 1'b1;
      @(posedge clk); #1;
      chk("init state", 32'(state), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("init state2",   32'(state),        32'd1);
      chk("init al_full",  32'(al_full_cfg),  32'd6);
      chk("init al_empty", 32'(al_empty_cfg), 32'd2);
      chk("init src_rd",   32'(src_rd),       32'd0);
      init = 1'b0;
      @(posedge clk); #1;
      chk("idle state", 32'(state), 32'd2);
      chk("idle flag",  32'(idle),  32'd1);
      umbral_full  = 3'd1;
      umbral_empty = 3'd7;

      // Lone lane 0 with two words
      load(0, 6'b010010);
      load(0, 6'b100100);
      run(5);
      exp_rd  = '{1:4'h1, 2:4'h1, default:4'h0};
      exp_wr  = '{2:1'b1, 3:1'b1, default:1'b0};
      exp_dat = '{2:6'h12, 3:6'h24, default:6'h0};
      check_run("t2", 5);
      chk("t2 st0",   32'(st_log[0]),   32'd2);
      chk("t2 st1",   32'(st_log[1]),   32'd3);
      chk("t2 idle3", 32'(idle_log[3]), 32'd0);
      chk("t2 idle4", 32'(idle_log[4]), 32'd1);

      // All lanes, two words each; rotation continues after lane 0
      for (int i = 0; i < 4; i++) begin
         load(i, 6'(i*16 + 1));
         load(i, 6'(i*16 + 2));
      end
      run(11);
      exp_rd  = '{1:4'h2, 2:4'h4, 3:4'h8, 4:4'h1, 5:4'h2, 6:4'h4, 7:4'h8, 8:4'h1, default:4'h0};
      exp_wr  = '{2:1'b1, 3:1'b1, 4:1'b1, 5:1'b1, 6:1'b1, 7:1'b1, 8:1'b1, 9:1'b1, default:1'b0};
      exp_dat = '{2:6'h11, 3:6'h21, 4:6'h31, 5:6'h01, 6:6'h12, 7:6'h22, 8:6'h32, 9:6'h02,
                  default:6'h0};
      check_run("t3", 11);
      chk("t3 idle9",  32'(idle_log[9]),  32'd0);
      chk("t3 idle10", 32'(idle_log[10]), 32'd1);
      chk("t3 hold al_full",  32'(al_full_cfg),  32'd6);
      chk("t3 hold al_empty", 32'(al_empty_cfg), 32'd2);

      // Almost-full backpressure mid-stream
      load(0, 6'h0A);
      load(1, 6'h1A);
      load(2, 6'h2A);
      load(3, 6'h3A);
      clear_sched();
      al_sched[3] = 1'b1;
      al_sched[4] = 1'b1;
      run(9);
      exp_rd  = '{1:4'h2, 2:4'h4, 5:4'h8, 6:4'h1, default:4'h0};
      exp_wr  = '{2:1'b1, 3:1'b1, 6:1'b1, 7:1'b1, default:1'b0};
      exp_dat = '{2:6'h1A, 3:6'h2A, 6:6'h3A, 7:6'h0A, default:6'h0};
      check_run("t4", 9);
      chk("t4 st4",   32'(st_log[4]),   32'd3);
      chk("t4 idle8", 32'(idle_log[8]), 32'd1);

      // Write while destination full
      load(1, 6'h15);
      clear_sched();
      full_sched[2] = 1'b1;
      run(6);
      exp_rd  = '{1:4'h2, default:4'h0};
      exp_wr  = '{2:1'b1, default:1'b0};
      exp_dat = '{2:6'h15, default:6'h0};
      check_run("t5", 6);
      chk("t5 err2", 32'(err_log[2]), 32'd0);
      chk("t5 err3", 32'(err_log[3]), 32'(ERR_EXP));
      chk("t5 err5", 32'(err_log[5]), 32'(ERR_EXP));

      // Asynchronous reset while ACTIVE with a write in flight
      clear_sched();
      load(2, 6'h2B);
      load(2, 6'h2C);
      load(2, 6'h2D);
      run(2);
      chk("t6 pre state",  32'(state),  32'd3);
      chk("t6 pre src_rd", 32'(src_rd), 32'h4);
      chk("t6 pre dst_wr", 32'(dst_wr), 32'd1);
      #2;
      RESET_L = 1'b0;
      #1;
      chk("t6 state",    32'(state),        32'd0);
      chk("t6 src_rd",   32'(src_rd),       32'd0);
      chk("t6 dst_wr",   32'(dst_wr),       32'd0);
      chk("t6 dst_data", 32'(dst_data),     32'd0);
      chk("t6 al_full",  32'(al_full_cfg),  32'd0);
      chk("t6 al_empty", 32'(al_empty_cfg), 32'd0);
      chk("t6 idle",     32'(idle),         32'd0);
      chk("t6 err",      32'(err_full),     32'd0);
      @(posedge clk); #1;
      chk("t6 hold state",  32'(state),  32'd0);
      chk("t6 hold dst_wr", 32'(dst_wr), 32'd0);

      chk("no read of empty", 32'(bad_rd), 32'd0);
      chk("src_rd one-hot",   32'(bad_oh), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
